flow_decoder: RTL

- Registered successor to the combinational instruction decoder: splits the instruction into fields and resolves jump, call and return.
- Owns a parametrised hardware return-address stack (RAS), so callers no longer manage return addresses.
- Sits between instruction fetch and the ALU/register file.
- Uses a valid/ready handshake on both sides and drives the PC load path.

---
 rtl/flow_pkg.sv | 55 +++++
 rtl/flow_decoder_if.sv | 51 +++++
 rtl/ret_addr_stack.sv | 51 +++++
 rtl/flow_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared opcodes, instruction field positions and control-class decode helpers
// for the flow decoder.
package flow_pkg;

    localparam logic [4:0] JMP     = 5'h10;
    localparam logic [4:0] IF0JUMP = 5'h11;
    localparam logic [4:0] IF1JUMP = 5'h12;
    localparam logic [4:0] CALL    = 5'h13;
    localparam logic [4:0] CAL0    = 5'h14;
    localparam logic [4:0] CAL1    = 5'h15;
    localparam logic [4:0] RET     = 5'h16;
    localparam logic [4:0] RET0    = 5'h17;
    localparam logic [4:0] RET1    = 5'h18;

    localparam int unsigned OP_MSB      = 36;
    localparam int unsigned OP_LSB      = 32;
    localparam int unsigned SRC1_MSB    = 31;
    localparam int unsigned SRC1_LSB    = 24;
    localparam int unsigned SRC2_MSB    = 23;
    localparam int unsigned SRC2_LSB    = 16;
    localparam int unsigned DST_MSB     = 15;
    localparam int unsigned DST_LSB     = 8;
    localparam int unsigned SRC1_CH_MSB = 5;
    localparam int unsigned SRC1_CH_LSB = 4;
    localparam int unsigned SRC2_CH_MSB = 3;
    localparam int unsigned SRC2_CH_LSB = 2;
    localparam int unsigned DST_CH_MSB  = 1;
    localparam int unsigned DST_CH_LSB  = 0;

    typedef enum logic [1:0] {
        CtlNone,
        CtlJump,
        CtlCall,
        CtlReturn
    } ctl_class_e;

    function automatic ctl_class_e op_class(input logic [4:0] op);
        case (op)
            JMP, IF0JUMP, IF1JUMP: return CtlJump;
            CALL, CAL0, CAL1:      return CtlCall;
            RET, RET0, RET1:       return CtlReturn;
            default:               return CtlNone;
        endcase
    endfunction

    // Condition only; the class decides whether the opcode is control flow at all.
    function automatic logic op_taken(input logic [4:0] op, input logic zero);
        case (op)
            IF0JUMP, CAL0, RET0: return !zero;
            IF1JUMP, CAL1, RET1: return zero;
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/flow_decoder_if.sv
// Fetch-side and execute-side handshake plus decoded outputs of the flow decoder.
// master = fetch/execute environment, slave = decoder.
interface flow_decoder_if #(
    parameter int unsigned PC_WIDTH          = 5,
    parameter int unsigned OPCODE_WIDTH      = 5,
    parameter int unsigned VALUE_WIDTH       = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 40,
    parameter int unsigned STACK_DEPTH       = 4
);
    localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]          pc_in;
    logic                         zero_flag;
    logic                         in_valid;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [OPCODE_WIDTH-1:0]      op_code;
    logic [VALUE_WIDTH-1:0]       source1;
    logic [VALUE_WIDTH-1:0]       source2;
    logic [VALUE_WIDTH-1:0]       destination;
    logic [1:0]                   source1_choice;
    logic [1:0]                   source2_choice;
    logic [1:0]                   destination_choice;
    logic                         pc_load;
    logic [PC_WIDTH-1:0]          pc_next;
    logic                         jmp;
    logic                         cal;
    logic                         ret;
    logic [DEPTH_WIDTH-1:0]       stack_depth;
    logic                         stack_overflow;
    logic                         stack_underflow;

    modport master (
        output instr, pc_in, zero_flag, in_valid, out_ready,
        input  in_ready, out_valid, op_code, source1, source2, destination,
        input  source1_choice, source2_choice, destination_choice,
        input  pc_load, pc_next, jmp, cal, ret,
        input  stack_depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  instr, pc_in, zero_flag, in_valid, out_ready,
        output in_ready, out_valid, op_code, source1, source2, destination,
        output source1_choice, source2_choice, destination_choice,
        output pc_load, pc_next, jmp, cal, ret,
        output stack_depth, stack_overflow, stack_underflow
    );

endinterface

// File: rtl/ret_addr_stack.sv
// Parametrised return-address LIFO; o_top is the entry a pop would return.
// Push has priority if both strobes are asserted; callers gate on full/empty.
module ret_addr_stack #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_top,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [AW:0]      w_count_m1;

    assign w_wr_idx   = r_count[AW-1:0];
    assign w_count_m1 = r_count - 1'b1;
    assign w_top_idx  = w_count_m1[AW-1:0];

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_top   = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_count <= w_count_m1;
        end
    end

    // Storage is not reset; an empty pointer makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/flow_decoder.sv
// Registered instruction decoder resolving jump/call/return with an internal RAS.
// FLOW_ERR_TRAP_EN: stack overflow/underflow redirects the PC to TRAP_ADDR.
module flow_decoder
    import flow_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = 5,
    parameter int unsigned OPCODE_WIDTH      = 5,
    parameter int unsigned VALUE_WIDTH       = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 40,
    parameter int unsigned STACK_DEPTH       = 4,
    parameter int unsigned TRAP_ADDR         = 0
) (
    input logic            clk,
    input logic            rst_n,
    flow_decoder_if.slave  bus
);
    localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                    w_accept;
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [VALUE_WIDTH-1:0]  w_src1;
    logic [VALUE_WIDTH-1:0]  w_src2;
    logic [VALUE_WIDTH-1:0]  w_dst;
    logic [1:0]              w_src1_ch;
    logic [1:0]              w_src2_ch;
    logic [1:0]              w_dst_ch;
    ctl_class_e              w_class;
    logic                    w_cond;
    logic                    w_take_jump;
    logic                    w_take_call;
    logic                    w_take_ret;

    logic                    w_full;
    logic                    w_empty;
    logic [PC_WIDTH-1:0]     w_top;
    logic [PC_WIDTH-1:0]     w_ret_addr;
    logic [PC_WIDTH-1:0]     w_trap_pc;
    logic [DEPTH_WIDTH-1:0]  w_count;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_ovf;
    logic                    w_udf;
    logic                    w_jmp;
    logic                    w_cal;
    logic                    w_ret;
    logic                    w_pc_load;
    logic [PC_WIDTH-1:0]     w_pc_next;
    logic                    w_unused_bits;

    logic                    r_out_valid;
    logic [OPCODE_WIDTH-1:0] r_op_code;
    logic [VALUE_WIDTH-1:0]  r_source1;
    logic [VALUE_WIDTH-1:0]  r_source2;
    logic [VALUE_WIDTH-1:0]  r_destination;
    logic [1:0]              r_source1_choice;
    logic [1:0]              r_source2_choice;
    logic [1:0]              r_destination_choice;
    logic                    r_pc_load;
    logic [PC_WIDTH-1:0]     r_pc_next;
    logic                    r_jmp;
    logic                    r_cal;
    logic                    r_ret;
    logic                    r_overflow;
    logic                    r_underflow;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign w_opcode  = bus.instr[OP_MSB:OP_LSB];
    assign w_src1    = bus.instr[SRC1_MSB:SRC1_LSB];
    assign w_src2    = bus.instr[SRC2_MSB:SRC2_LSB];
    assign w_dst     = bus.instr[DST_MSB:DST_LSB];
    assign w_src1_ch = bus.instr[SRC1_CH_MSB:SRC1_CH_LSB];
    assign w_src2_ch = bus.instr[SRC2_CH_MSB:SRC2_CH_LSB];
    assign w_dst_ch  = bus.instr[DST_CH_MSB:DST_CH_LSB];

    assign w_class     = op_class(w_opcode);
    assign w_cond      = op_taken(w_opcode, bus.zero_flag);
    assign w_take_jump = (w_class == CtlJump) && w_cond;
    assign w_take_call = (w_class == CtlCall) && w_cond;
    assign w_take_ret  = (w_class == CtlReturn) && w_cond;

    assign w_ret_addr = bus.pc_in + PC_WIDTH'(1);
    assign w_trap_pc  = PC_WIDTH'(TRAP_ADDR);

    // Spare instruction bits carry no meaning; the trap PC is unused without the feature.
    assign w_unused_bits = ^{bus.instr[INSTRUCTION_WIDTH-1:OP_MSB+1],
                             bus.instr[DST_LSB-1:SRC1_CH_MSB+1], w_trap_pc};

    always_comb begin
        w_jmp     = 1'b0;
        w_cal     = 1'b0;
        w_ret     = 1'b0;
        w_pc_load = 1'b0;
        w_pc_next = '0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf     = 1'b0;
        w_udf     = 1'b0;
        if (w_take_jump) begin
            w_jmp     = 1'b1;
            w_pc_load = 1'b1;
            w_pc_next = w_src1[PC_WIDTH-1:0];
        end else if (w_take_call) begin
            if (w_full) begin
                w_ovf = 1'b1;
`ifdef FLOW_ERR_TRAP_EN
                w_jmp     = 1'b1;
                w_pc_load = 1'b1;
                w_pc_next = w_trap_pc;
`endif
            end else begin
                w_push    = 1'b1;
                w_jmp     = 1'b1;
                w_cal     = 1'b1;
                w_pc_load = 1'b1;
                w_pc_next = w_src1[PC_WIDTH-1:0];
            end
        end else if (w_take_ret) begin
            if (w_empty) begin
                w_udf = 1'b1;
`ifdef FLOW_ERR_TRAP_EN
                w_jmp     = 1'b1;
                w_pc_load = 1'b1;
                w_pc_next = w_trap_pc;
`endif
            end else begin
                w_pop     = 1'b1;
                w_ret     = 1'b1;
                w_pc_load = 1'b1;
                w_pc_next = w_top;
            end
        end
    end

    ret_addr_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push && w_accept),
        .i_pop   (w_pop && w_accept),
        .i_data  (w_ret_addr),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid          <= 1'b0;
            r_op_code            <= '0;
            r_source1            <= '0;
            r_source2            <= '0;
            r_destination        <= '0;
            r_source1_choice     <= '0;
            r_source2_choice     <= '0;
            r_destination_choice <= '0;
            r_pc_load            <= 1'b0;
            r_pc_next            <= '0;
            r_jmp                <= 1'b0;
            r_cal                <= 1'b0;
            r_ret                <= 1'b0;
            r_overflow           <= 1'b0;
            r_underflow          <= 1'b0;
        end else if (w_accept) begin
            r_out_valid          <= 1'b1;
            r_op_code            <= w_opcode;
            r_source1            <= w_src1;
            r_source2            <= w_src2;
            r_destination        <= w_dst;
            r_source1_choice     <= w_src1_ch;
            r_source2_choice     <= w_src2_ch;
            r_destination_choice <= w_dst_ch;
            r_pc_load            <= w_pc_load;
            r_pc_next            <= w_pc_next;
            r_jmp                <= w_jmp;
            r_cal                <= w_cal;
            r_ret                <= w_ret;
            r_overflow           <= r_overflow | w_ovf;
            r_underflow          <= r_underflow | w_udf;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid          = r_out_valid;
    assign bus.op_code            = r_op_code;
    assign bus.source1            = r_source1;
    assign bus.source2            = r_source2;
    assign bus.destination        = r_destination;
    assign bus.source1_choice     = r_source1_choice;
    assign bus.source2_choice     = r_source2_choice;
    assign bus.destination_choice = r_destination_choice;
    assign bus.pc_load            = r_pc_load;
    assign bus.pc_next            = r_pc_next;
    assign bus.jmp                = r_jmp;
    assign bus.cal                = r_cal;
    assign bus.ret                = r_ret;
    assign bus.stack_depth        = w_count;
    assign bus.stack_overflow     = r_overflow;
    assign bus.stack_underflow    = r_underflow;

endmodule
